// File: rtl/fft_output_unit.sv
// Frame buffer for the 64-point FFT: captures 8 lanes x 8 words in
// digit-transposed order and streams the bins out in natural order.
module fft_output_unit #(
    parameter int DW     = 10,
    parameter int N_LANE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    input  logic [N_LANE*DW-1:0] dinre,
    input  logic [N_LANE*DW-1:0] dinim,
    output logic                 dout_valid,
    output logic [DW-1:0]        doutre,
    output logic [DW-1:0]        doutim,
    output logic [5:0]           dout_index,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int DEPTH = N_LANE * N_LANE;
    localparam int WW    = $clog2(N_LANE);
    localparam int AW    = 2 * WW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WW-1:0]     wcnt;
    logic [AW-1:0]     ocnt;
    logic              capture;
    logic [2*DW-1:0]   mem [DEPTH];

    assign capture = din_valid && (state != SEND);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (din_valid) state_nxt = LOAD;
            LOAD: begin
                if (din_valid && wcnt == WW'(N_LANE - 1))
                    state_nxt = SEND;
            end
            SEND: if (ocnt == AW'(DEPTH - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Word counter wraps to 0 on the 8th capture, ready for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            ocnt <= '0;
        end else begin
            if (capture) wcnt <= wcnt + 1'b1;
            if (state == SEND) ocnt <= ocnt + 1'b1;
            else               ocnt <= '0;
        end
    end

    // Lane j of word k is bin 8*j+k: address is {lane, word}.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int j = 0; j < N_LANE; j++) begin
                mem[{WW'(j), wcnt}] <= {dinre[j*DW +: DW], dinim[j*DW +: DW]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            doutre     <= '0;
            doutim     <= '0;
            dout_index <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= din_valid && (state == SEND);
            if (state == SEND) begin
                dout_valid <= 1'b1;
                doutre     <= mem[ocnt][2*DW-1:DW];
                doutim     <= mem[ocnt][DW-1:0];
                dout_index <= 6'(ocnt);
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_output_unit.sv
// Bench for fft_output_unit: table-driven constant frames, directed
// corner sequences and random frames against a natural-order model.
module tb_fft_output_unit;

    localparam int DW = 10;
    localparam int NL = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din_valid = 1'b0;
    logic [NL*DW-1:0] dinre = '0;
    logic [NL*DW-1:0] dinim = '0;
    logic             dout_valid;
    logic [DW-1:0]    doutre;
    logic [DW-1:0]    doutim;
    logic [5:0]       dout_index;
    logic             busy;
    logic             frame_err;

    fft_output_unit #(.DW(DW), .N_LANE(NL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .dinre      (dinre),
        .dinim      (dinim),
        .dout_valid (dout_valid),
        .doutre     (doutre),
        .doutim     (doutim),
        .dout_index (dout_index),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [DW-1:0] exp_re;
        logic [DW-1:0] exp_im;
    } const_vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Frame as natural-order bins, and the expected output stream.
    logic [DW-1:0] fre [64];
    logic [DW-1:0] fim [64];
    logic [DW-1:0] ere [64];
    logic [DW-1:0] eim [64];
    int            gap [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp(input int off);
        for (int m = 0; m < 64; m++) begin
            fre[m] = DW'(m + off);
            fim[m] = DW'(63 - m + off);
            ere[m] = fre[m];
            eim[m] = fim[m];
        end
    endtask

    task automatic no_gaps();
        for (int k = 0; k < 8; k++) gap[k] = 0;
    endtask

    // Word k, lane j carries bin 8*j+k.
    task automatic load_frame();
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                din_valid = 1'b0;
                step();
                if (k > 0) begin
                    check("stall_busy", busy, 1);
                    check("stall_no_out", dout_valid, 0);
                end
            end
            din_valid = 1'b1;
            for (int j = 0; j < NL; j++) begin
                dinre[j*DW +: DW] = fre[8*j + k];
                dinim[j*DW +: DW] = fim[8*j + k];
            end
            step();
            check("load_busy", busy, 1);
        end
        din_valid = 1'b0;
        check("send_latency_valid", dout_valid, 0);
        check("send_latency_busy", busy, 1);
    endtask

    task automatic collect(input int err_lo, input int err_hi,
                           input int rst_at, output bit aborted);
        aborted = 1'b0;
        for (int m = 0; m < 64; m++) begin
            step();
            if (m == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_mid_send",
                      {dout_valid, doutre, doutim, dout_index, busy, frame_err},
                      0);
                aborted = 1'b1;
                din_valid = 1'b0;
                return;
            end
            check("dout_valid", dout_valid, 1);
            check("doutre", doutre, ere[m]);
            check("doutim", doutim, eim[m]);
            check("dout_index", dout_index, m);
            check("busy_send", busy, (m != 63));
            check("frame_err", frame_err,
                  ((m - 1) >= err_lo) && ((m - 1) <= err_hi));
            din_valid = (m >= err_lo) && (m <= err_hi);
        end
        din_valid = 1'b0;
    endtask

    task automatic tail();
        step();
        check("tail_valid", dout_valid, 0);
        check("tail_busy", busy, 0);
        check("tail_index_hold", dout_index, 63);
        check("tail_re_hold", doutre, ere[63]);
    endtask

    initial begin
        const_vec_t tbl [3];
        bit ab;

        tbl[0] = '{re: 10'h3FF, im: 10'h200, exp_re: 10'h3FF, exp_im: 10'h200};
        tbl[1] = '{re: 10'h000, im: 10'h3FF, exp_re: 10'h000, exp_im: 10'h3FF};
        tbl[2] = '{re: 10'h155, im: 10'h2AA, exp_re: 10'h155, exp_im: 10'h2AA};

        #12;
        check("reset_outputs",
              {dout_valid, doutre, doutim, dout_index, busy, frame_err}, 0);
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 0);
        check("idle_valid", dout_valid, 0);

        // Basic reorder
        set_ramp(0);
        no_gaps();
        load_frame();
        collect(-10, -10, -1, ab);
        tail();

        // Stalled load
        no_gaps();
        gap[3] = 3;
        gap[7] = 1;
        load_frame();
        collect(-10, -10, -1, ab);
        tail();

        // Overrun at m=10,11
        no_gaps();
        load_frame();
        collect(10, 11, -1, ab);
        tail();

        // Back-to-back: second frame starts in the first IDLE cycle
        load_frame();
        collect(-10, -10, -1, ab);
        set_ramp(100);
        load_frame();
        collect(-10, -10, -1, ab);
        tail();

        // Reset mid-SEND, then a fresh frame
        set_ramp(5);
        load_frame();
        collect(-10, -10, 20, ab);
        check("reset_aborted", ab, 1);
        step();
        check("in_reset_busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("after_reset_idle", busy, 0);
        set_ramp(0);
        load_frame();
        collect(-10, -10, -1, ab);
        tail();

        // Extreme / constant values, bit-exact
        for (int t = 0; t < 3; t++) begin
            for (int m = 0; m < 64; m++) begin
                fre[m] = tbl[t].re;
                fim[m] = tbl[t].im;
                ere[m] = tbl[t].exp_re;
                eim[m] = tbl[t].exp_im;
            end
            no_gaps();
            load_frame();
            collect(-10, -10, -1, ab);
            tail();
        end

        // Random frames with random gaps and overrun windows
        for (int r = 0; r < 4; r++) begin
            int lo;
            for (int m = 0; m < 64; m++) begin
                fre[m] = DW'($urandom_range(0, 1023));
                fim[m] = DW'($urandom_range(0, 1023));
                ere[m] = fre[m];
                eim[m] = fim[m];
            end
            for (int k = 0; k < 8; k++) gap[k] = $urandom_range(0, 2);
            lo = $urandom_range(0, 55);
            load_frame();
            collect(lo, lo + $urandom_range(0, 6), -1, ab);
            tail();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
